conv_engine_param: RTL and testbench

//  Parametrised successor to the fixed 4x4/3x3 convolution datapath: NxN image, KxK kernel, valid 2D conv.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_mac.sv | 52 +++++
 rtl/conv_engine_param.sv | 198 +++++++++++++++++++
 tb/tb_conv_engine_param.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time width helpers for the parametrised convolution engine.
package conv_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StOut
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of an index that covers 0..v-1, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned v);
        return (v <= 1) ? 1 : clog2_f(v);
    endfunction

    // Accumulator width that holds K*K full-scale DW x DW products without overflow.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned k);
        return 2 * dw + clog2_f(k * k);
    endfunction

    // Side of the valid-convolution output map.
    function automatic int unsigned out_side(input int unsigned n, input int unsigned k);
        return n - k + 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate datapath: DW x DW product into an AW accumulator.
// Output view is the low OW bits, or an unsigned-saturated value when CONV_SAT_EN is defined.
module conv_mac
    import conv_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 19,
    parameter int unsigned OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [OW-1:0] res
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;

    assign prod = (2 * DW)'(a) * (2 * DW)'(b);

    // Next accumulator value: clr restarts the sum with this cycle's product.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? AW'(prod) : acc_q + AW'(prod);
        end
    end

    // Accumulator register, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    if (AW > OW) begin : g_narrow
`ifdef CONV_SAT_EN
        assign res = (|acc_q[AW-1:OW]) ? {OW{1'b1}} : acc_q[OW-1:0];
`else
        assign res = acc_q[OW-1:0];
`endif
    end else begin : g_wide
        assign res = OW'(acc_q);
    end

endmodule

// File: rtl/conv_engine_param.sv
// Parametrised NxN image / KxK kernel valid 2D convolution engine.
// Operands stream in (image then kernel, row-major), results stream out row-major
// through one shared MAC at one product per cycle.
// Build option: CONV_SAT_EN selects unsigned saturation of results instead of truncation.
module conv_engine_param
    import conv_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 3,
    parameter int unsigned OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          done
);

    localparam int unsigned M    = out_side(N, K);
    localparam int unsigned NIMG = N * N;
    localparam int unsigned NKER = K * K;
    localparam int unsigned NTOT = NIMG + NKER;
    localparam int unsigned AW   = acc_w(DW, K);
    localparam int unsigned CW   = idx_w(NTOT);
    localparam int unsigned IAW  = idx_w(NIMG);
    localparam int unsigned KAW  = idx_w(NKER);
    localparam int unsigned PW   = idx_w(M);
    localparam int unsigned KW   = idx_w(K);

    if (K < 1 || N < K) begin : g_param_check
        $error("conv_engine_param: requires K >= 1 and N >= K");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [PW-1:0] pi_q, pi_d, pj_q, pj_d;
    logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
    logic          done_q, done_d;

    logic [DW-1:0] img_q [NIMG];
    logic [DW-1:0] ker_q [NKER];

    logic [IAW-1:0] img_waddr, img_raddr;
    logic [KAW-1:0] ker_waddr, ker_raddr;

    logic          mac_en, mac_clr;
    logic [OW-1:0] mac_res;

    logic last_beat, last_tap_col, last_tap_row, last_col, last_pix;

    assign last_beat    = (ld_cnt_q == CW'(NTOT - 1));
    assign last_tap_col = (kc_q == KW'(K - 1));
    assign last_tap_row = (kr_q == KW'(K - 1));
    assign last_col     = (pj_q == PW'(M - 1));
    assign last_pix     = (pi_q == PW'(M - 1)) && last_col;

    // Buffer write addresses from the load count, read addresses from pixel and tap counters.
    always_comb begin
        img_waddr = IAW'(ld_cnt_q);
        ker_waddr = KAW'(ld_cnt_q - CW'(NIMG));
        img_raddr = IAW'((32'(pi_q) + 32'(kr_q)) * N + 32'(pj_q) + 32'(kc_q));
        ker_raddr = KAW'(32'(kr_q) * K + 32'(kc_q));
    end

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        pi_d      = pi_q;
        pj_d      = pj_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        done_d    = 1'b0;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                // A start coinciding with the done pulse belongs to the finishing job.
                if (start && !done_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_beat) begin
                        ld_cnt_d = '0;
                        state_d  = StCompute;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CW'(1);
                    end
                end
            end
            StCompute: begin
                mac_en  = 1'b1;
                mac_clr = (kr_q == '0) && (kc_q == '0);
                if (last_tap_col) begin
                    kc_d = '0;
                    if (last_tap_row) begin
                        kr_d    = '0;
                        state_d = StOut;
                    end else begin
                        kr_d = kr_q + KW'(1);
                    end
                end else begin
                    kc_d = kc_q + KW'(1);
                end
            end
            StOut: begin
                out_valid = 1'b1;
                out_last  = last_pix;
                if (out_ready) begin
                    if (last_pix) begin
                        pi_d    = '0;
                        pj_d    = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCompute;
                        if (last_col) begin
                            pj_d = '0;
                            pi_d = pi_q + PW'(1);
                        end else begin
                            pj_d = pj_q + PW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and counters; reset aborts any job in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            ld_cnt_q <= '0;
            pi_q     <= '0;
            pj_q     <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            pi_q     <= pi_d;
            pj_q     <= pj_d;
            kr_q     <= kr_d;
            kc_q     <= kc_d;
            done_q   <= done_d;
        end
    end

    // Operand buffers: not reset, simply overwritten by each job's load phase.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            if (ld_cnt_q < CW'(NIMG)) begin
                img_q[img_waddr] <= in_data;
            end else begin
                ker_q[ker_waddr] <= in_data;
            end
        end
    end

    conv_mac #(
        .DW (DW),
        .AW (AW),
        .OW (OW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (img_q[img_raddr]),
        .b   (ker_q[ker_raddr]),
        .res (mac_res)
    );

    // The accumulator holds still in StOut, so the result stays stable while stalled.
    assign out_data = mac_res;
    assign done     = done_q;

endmodule

// File: tb/tb_conv_engine_param.sv
// Self-checking bench for conv_engine_param: a 4x4/3x3 instance and a 6x6/3x3 instance,
// checked against a direct sum-of-products model of the convolution.
module tb_conv_engine_param;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 8;
    localparam int unsigned NA = 4;
    localparam int unsigned KA = 3;
    localparam int unsigned NB = 6;
    localparam int unsigned KB = 3;
    localparam int unsigned TOTA = NA * NA + KA * KA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, busy, in_valid, in_ready, out_valid, out_ready, out_last, done;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_data;

    logic          b_start, b_busy, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic          b_out_last, b_done;
    logic [DW-1:0] b_in_data;
    logic [OW-1:0] b_out_data;

    int checks = 0;
    int errors = 0;

    int unsigned img_m [36];
    int unsigned ker_m [9];
    int unsigned exp_q [$];

    conv_engine_param #(.DW(DW), .N(NA), .K(KA), .OW(OW)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    conv_engine_param #(.DW(DW), .N(NB), .K(KB), .OW(OW)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .busy      (b_busy),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .done      (b_done)
    );

    // Reference pixel: plain sum of products, then truncated or saturated to OW bits.
    function automatic int unsigned ref_pix(input int unsigned n, input int unsigned k,
                                            input int unsigned i, input int unsigned j);
        longint unsigned s;
        longint unsigned omax;
        s = 0;
        omax = (longint'(1) << OW) - 1;
        for (int unsigned r = 0; r < k; r++) begin
            for (int unsigned c = 0; c < k; c++) begin
                s += longint'(img_m[(i + r) * n + j + c]) * longint'(ker_m[r * k + c]);
            end
        end
`ifdef CONV_SAT_EN
        return (s > omax) ? int'(omax) : int'(s);
`else
        return int'(s & omax);
`endif
    endfunction

    task automatic build_exp(input int unsigned n, input int unsigned k);
        exp_q.delete();
        for (int unsigned i = 0; i < n - k + 1; i++) begin
            for (int unsigned j = 0; j < n - k + 1; j++) begin
                exp_q.push_back(ref_pix(n, k, i, j));
            end
        end
    endtask

    task automatic fill_case1();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) img_m[r * 4 + c] = c + 1;
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) ker_m[r * 3 + c] = r + 1;
        end
        build_exp(NA, KA);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) img_m[i] = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++) ker_m[i] = $urandom_range(0, 255);
        build_exp(NA, KA);
    endtask

    // Stream stop_at operand beats into DUT A, optionally with idle gaps on in_valid.
    task automatic send_job(input bit do_start, input bit gaps, input int unsigned stop_at);
        int unsigned idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (idx < stop_at && guard < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = DW'(idx < NA * NA ? img_m[idx] : ker_m[idx - NA * NA]);
            acc = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != stop_at) begin
            errors++;
            $display("FAIL load_beats: accepted %0d beats, required %0d", idx, stop_at);
        end
    endtask

    // Drain DUT A's results against exp_q; ends on the cycle where done should be high.
    task automatic collect(input bit stall, input bit noise);
        int unsigned got;
        int unsigned mm;
        int guard;
        bit have_prev;
        logic [OW-1:0] prev;
        got = 0;
        guard = 0;
        have_prev = 1'b0;
        prev = '0;
        mm = exp_q.size();
        while (got < mm && guard < 5000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
            end
            if (out_valid) begin
                if (have_prev) begin
                    checks++;
                    if (out_data !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: out_data %0d while stalled, required %0d",
                                 out_data, prev);
                    end
                end
                prev = out_data;
                have_prev = 1'b1;
                if (out_ready) begin
                    checks++;
                    if (out_data !== OW'(exp_q[got])) begin
                        errors++;
                        $display("FAIL pixel[%0d]: out_data %0d, required %0d",
                                 got, out_data, exp_q[got]);
                    end
                    checks++;
                    if (out_last !== (got == mm - 1)) begin
                        errors++;
                        $display("FAIL out_last[%0d]: got %b, required %b",
                                 got, out_last, (got == mm - 1));
                    end
                    got++;
                    have_prev = 1'b0;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (got != mm) begin
            errors++;
            $display("FAIL result_count: received %0d results, required %0d", got, mm);
        end
        if (!stall) begin
            checks++;
            if (guard != int'(mm * (KA * KA + 1))) begin
                errors++;
                $display("FAIL throughput: %0d cycles, required %0d", guard, mm * (KA * KA + 1));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
    endtask

    task automatic step_done_low();
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, in_ready, out_valid, out_last, done, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_a: busy=%b in_ready=%b out_valid=%b out_last=%b done=%b data=%0d, required all 0",
                     busy, in_ready, out_valid, out_last, done, out_data);
        end
        checks++;
        if ({b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_out_data} !== '0) begin
            errors++;
            $display("FAIL reset_b: busy=%b in_ready=%b out_valid=%b out_last=%b done=%b data=%0d, required all 0",
                     b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_out_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_case1();
        send_job(1'b1, 1'b0, TOTA);
        collect(1'b0, 1'b0);
        step_done_low();
    endtask

    task automatic test_stall();
        fill_case1();
        send_job(1'b1, 1'b1, TOTA);
        collect(1'b1, 1'b0);
        step_done_low();
    endtask

    task automatic test_max();
        for (int i = 0; i < 16; i++) img_m[i] = 255;
        for (int i = 0; i < 9; i++) ker_m[i] = 255;
        build_exp(NA, KA);
        send_job(1'b1, 1'b0, TOTA);
        collect(1'b0, 1'b0);
        step_done_low();
    endtask

    task automatic test_abort();
        fill_case1();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                send_job(1'b1, 1'b0, 10);
            end else begin
                send_job(1'b1, 1'b0, TOTA);
                repeat (4) @(negedge clk);
            end
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, in_ready, out_valid, out_last, done, out_data} !== '0) begin
                errors++;
                $display("FAIL abort_%0d: busy=%b in_ready=%b out_valid=%b out_last=%b done=%b data=%0d, required all 0",
                         phase, busy, in_ready, out_valid, out_last, done, out_data);
            end
            rst = 1'b1;
            @(negedge clk);
        end
        send_job(1'b1, 1'b0, TOTA);
        collect(1'b0, 1'b0);
        step_done_low();
    endtask

    task automatic test_ignore();
        fill_case1();
        send_job(1'b1, 1'b0, TOTA);
        collect(1'b0, 1'b1);
        step_done_low();
    endtask

    task automatic test_done_start();
        fill_random();
        send_job(1'b1, 1'b0, TOTA);
        collect(1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done: busy=%b, required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_after_done: busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        fill_random();
        send_job(1'b0, 1'b0, TOTA);
        collect(1'b0, 1'b0);
        step_done_low();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            fill_random();
            send_job(1'b1, 1'b1, TOTA);
            collect(1'b1, 1'b0);
            step_done_low();
        end
    endtask

    task automatic test_n6();
        int unsigned idx;
        int unsigned got;
        int guard;
        bit acc;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) img_m[r * 6 + c] = r + c;
        end
        for (int i = 0; i < 9; i++) ker_m[i] = 1;
        build_exp(NB, KB);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < NB * NB + KB * KB && guard < 2000) begin
            b_in_valid = 1'b1;
            b_in_data  = DW'(idx < NB * NB ? img_m[idx] : ker_m[idx - NB * NB]);
            acc = b_in_ready;
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        got = 0;
        guard = 0;
        while (got < exp_q.size() && guard < 5000) begin
            if (b_out_valid) begin
                checks++;
                if (b_out_data !== OW'(exp_q[got])) begin
                    errors++;
                    $display("FAIL n6_pixel[%0d]: out_data %0d, required %0d",
                             got, b_out_data, exp_q[got]);
                end
                checks++;
                if (b_out_last !== (got == exp_q.size() - 1)) begin
                    errors++;
                    $display("FAIL n6_last[%0d]: got %b, required %b",
                             got, b_out_last, (got == exp_q.size() - 1));
                end
                got++;
            end
            @(negedge clk);
            guard++;
        end
        b_out_ready = 1'b0;
        checks++;
        if (got != 16 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL n6_done: %0d results done=%b, required 16 results done=1", got, b_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        b_start = 1'b0;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_max();
        test_abort();
        test_ignore();
        test_done_start();
        test_random();
        test_n6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
